// File: rtl/vx_ecc_pkg.sv
// Shared SECDED helpers: codeword width derivation, data-bit placement and lane status.
package vx_ecc_pkg;

    typedef enum logic [1:0] {
        LANE_CLEAN     = 2'd0,
        LANE_CORRECTED = 2'd1,
        LANE_INVALID   = 2'd2
    } lane_status_e;

    // Smallest r with 2^r >= data_bits + r + 1.
    function automatic int calc_hamming_bits(input int data_bits);
        int r;
        r = 1;
        while ((1 << r) < data_bits + r + 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int calc_encoded_bits(input int data_bits);
        return data_bits + calc_hamming_bits(data_bits) + 1;
    endfunction

    // Hamming position (1-based) that holds data bit idx: the idx-th non-power-of-two position.
    function automatic int data_position(input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = -1;
        while (cnt < idx) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) != 0) begin
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/vx_secded_lane.sv
// One SECDED lane: syndrome/parity/extract on the raw codeword, then classify and
// correct using the syndrome, parity and data held in the first pipeline stage.
module vx_secded_lane
    import vx_ecc_pkg::*;
#(
    parameter int DATA_BITS    = 128,
    parameter int HAMMING_BITS = calc_hamming_bits(DATA_BITS),
    parameter int ENCODED_BITS = calc_encoded_bits(DATA_BITS)
) (
    input  logic [ENCODED_BITS-1:0] raw_code,
    output logic [HAMMING_BITS-1:0] raw_syndrome,
    output logic                    raw_parity,
    output logic [DATA_BITS-1:0]    raw_data,
    input  logic [DATA_BITS-1:0]    held_data,
    input  logic [HAMMING_BITS-1:0] syndrome,
    input  logic                    parity,
    output logic [DATA_BITS-1:0]    data,
    output lane_status_e            status
);

    function automatic logic [ENCODED_BITS-1:0] syndrome_mask(input int bit_idx);
        logic [ENCODED_BITS-1:0] m;
        m = '0;
        for (int pos = 1; pos < ENCODED_BITS; pos++) begin
            if (((pos >> bit_idx) & 1) != 0) begin
                m[pos-1] = 1'b1;
            end
        end
        return m;
    endfunction

    logic flip;

    genvar gi;
    generate
        for (gi = 0; gi < HAMMING_BITS; gi++) begin : g_syn
            localparam logic [ENCODED_BITS-1:0] SYN_MASK = syndrome_mask(gi);
            assign raw_syndrome[gi] = ^(raw_code & SYN_MASK);
        end
    endgenerate

    assign raw_parity = ^raw_code;

    // Odd parity means a single (correctable) error unless the syndrome points outside the word.
    always_comb begin
        flip   = 1'b0;
        status = LANE_CLEAN;
        if (parity) begin
            if (syndrome == '0) begin
                status = LANE_CORRECTED;
            end else if (int'(syndrome) < ENCODED_BITS) begin
                status = LANE_CORRECTED;
                flip   = 1'b1;
            end else begin
                status = LANE_INVALID;
            end
        end else if (syndrome != '0) begin
            status = LANE_INVALID;
        end
    end

    // Check-bit positions are never flipped into data, so only data positions are corrected.
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_data
            localparam int POS = data_position(gi);
            assign raw_data[gi] = raw_code[POS-1];
            assign data[gi]     = held_data[gi] ^ (flip & (syndrome == HAMMING_BITS'(POS)));
        end
    endgenerate

endmodule

// File: rtl/vx_secded_dec_pipe.sv
// Two-stage multi-lane SECDED decoder with ready/valid flow control, saturating
// error counters and a first-uncorrectable-error log.
module vx_secded_dec_pipe
    import vx_ecc_pkg::*;
#(
    parameter int DATA_BITS = 128,
    parameter int LANES     = 4,
    parameter int TAG_BITS  = 8,
    parameter int CNT_BITS  = 16,
    localparam int HAMMING_BITS = calc_hamming_bits(DATA_BITS),
    localparam int ENCODED_BITS = calc_encoded_bits(DATA_BITS),
    localparam int LANE_BITS    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*ENCODED_BITS-1:0] in_data,
    input  logic [TAG_BITS-1:0]           in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_BITS-1:0]    out_data,
    output logic [TAG_BITS-1:0]           out_tag,
    output logic [LANES-1:0]              out_corrected,
    output logic [LANES-1:0]              out_invalid,
    output logic [CNT_BITS-1:0]           cnt_corr,
    output logic [CNT_BITS-1:0]           cnt_uncorr,
    input  logic                          clr,
    output logic                          log_valid,
    output logic [TAG_BITS-1:0]           log_tag,
    output logic [LANE_BITS-1:0]          log_lane,
    output logic [HAMMING_BITS-1:0]       log_syndrome,
    output logic                          irq
);

    logic [LANES*HAMMING_BITS-1:0] raw_syndrome;
    logic [LANES-1:0]              raw_parity;
    logic [LANES*DATA_BITS-1:0]    raw_data;
    logic [LANES*DATA_BITS-1:0]    lane_data;
    lane_status_e                  lane_status [LANES];
    logic [LANES-1:0]              lane_corrected;
    logic [LANES-1:0]              lane_invalid;

    logic                          s1_valid_reg;
    logic [LANES*DATA_BITS-1:0]    s1_data_reg;
    logic [LANES*HAMMING_BITS-1:0] s1_syndrome_reg;
    logic [LANES-1:0]              s1_parity_reg;
    logic [TAG_BITS-1:0]           s1_tag_reg;

    logic                          out_valid_reg;
    logic [LANES*DATA_BITS-1:0]    out_data_reg;
    logic [TAG_BITS-1:0]           out_tag_reg;
    logic [LANES-1:0]              out_corrected_reg;
    logic [LANES-1:0]              out_invalid_reg;
    logic [LANES*HAMMING_BITS-1:0] s2_syndrome_reg;

    logic [CNT_BITS-1:0]     cnt_corr_reg, cnt_corr_next;
    logic [CNT_BITS-1:0]     cnt_uncorr_reg, cnt_uncorr_next;
    logic                    log_valid_reg, log_valid_next;
    logic [TAG_BITS-1:0]     log_tag_reg, log_tag_next;
    logic [LANE_BITS-1:0]    log_lane_reg, log_lane_next;
    logic [HAMMING_BITS-1:0] log_syndrome_reg, log_syndrome_next;
    logic                    irq_reg;

    logic s1_advance, s2_advance, in_fire, out_fire;
    logic any_corr, any_inv, log_capture;
    logic [LANE_BITS-1:0]    first_lane;
    logic [HAMMING_BITS-1:0] first_syndrome;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            vx_secded_lane #(
                .DATA_BITS    (DATA_BITS),
                .HAMMING_BITS (HAMMING_BITS),
                .ENCODED_BITS (ENCODED_BITS)
            ) u_lane (
                .raw_code     (in_data[gi*ENCODED_BITS +: ENCODED_BITS]),
                .raw_syndrome (raw_syndrome[gi*HAMMING_BITS +: HAMMING_BITS]),
                .raw_parity   (raw_parity[gi]),
                .raw_data     (raw_data[gi*DATA_BITS +: DATA_BITS]),
                .held_data    (s1_data_reg[gi*DATA_BITS +: DATA_BITS]),
                .syndrome     (s1_syndrome_reg[gi*HAMMING_BITS +: HAMMING_BITS]),
                .parity       (s1_parity_reg[gi]),
                .data         (lane_data[gi*DATA_BITS +: DATA_BITS]),
                .status       (lane_status[gi])
            );
            assign lane_corrected[gi] = (lane_status[gi] == LANE_CORRECTED);
            assign lane_invalid[gi]   = (lane_status[gi] == LANE_INVALID);
        end
    endgenerate

    assign s2_advance = !out_valid_reg || out_ready;
    assign s1_advance = !s1_valid_reg || s2_advance;
    assign in_ready   = reset && s1_advance;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (s1_advance) s1_valid_reg  <= in_fire;
            if (s2_advance) out_valid_reg <= s1_valid_reg;
        end
    end

    // Payload registers only move with their valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_data_reg     <= raw_data;
            s1_syndrome_reg <= raw_syndrome;
            s1_parity_reg   <= raw_parity;
            s1_tag_reg      <= in_tag;
        end
        if (s2_advance && s1_valid_reg) begin
            out_data_reg      <= lane_data;
            out_tag_reg       <= s1_tag_reg;
            out_corrected_reg <= lane_corrected;
            out_invalid_reg   <= lane_invalid;
            s2_syndrome_reg   <= s1_syndrome_reg;
        end
    end

    always_comb begin
        any_corr          = |out_corrected_reg;
        any_inv           = |out_invalid_reg;
        cnt_corr_next     = cnt_corr_reg;
        cnt_uncorr_next   = cnt_uncorr_reg;
        first_lane        = '0;
        first_syndrome    = '0;
        log_valid_next    = log_valid_reg;
        log_tag_next      = log_tag_reg;
        log_lane_next     = log_lane_reg;
        log_syndrome_next = log_syndrome_reg;

        if (clr) begin
            cnt_corr_next   = '0;
            cnt_uncorr_next = '0;
        end else if (out_fire) begin
            if (any_corr && (cnt_corr_reg != {CNT_BITS{1'b1}}))
                cnt_corr_next = cnt_corr_reg + CNT_BITS'(1);
            if (any_inv && (cnt_uncorr_reg != {CNT_BITS{1'b1}}))
                cnt_uncorr_next = cnt_uncorr_reg + CNT_BITS'(1);
        end

        // Descending scan so the lowest invalid lane is the one left standing.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (out_invalid_reg[i]) begin
                first_lane     = LANE_BITS'(i);
                first_syndrome = s2_syndrome_reg[i*HAMMING_BITS +: HAMMING_BITS];
            end
        end

        log_capture = out_fire && any_inv && (!log_valid_reg || clr);
        if (log_capture) begin
            log_valid_next    = 1'b1;
            log_tag_next      = out_tag_reg;
            log_lane_next     = first_lane;
            log_syndrome_next = first_syndrome;
        end else if (clr) begin
            log_valid_next    = 1'b0;
            log_tag_next      = '0;
            log_lane_next     = '0;
            log_syndrome_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_corr_reg     <= '0;
            cnt_uncorr_reg   <= '0;
            log_valid_reg    <= 1'b0;
            log_tag_reg      <= '0;
            log_lane_reg     <= '0;
            log_syndrome_reg <= '0;
            irq_reg          <= 1'b0;
        end else begin
            cnt_corr_reg     <= cnt_corr_next;
            cnt_uncorr_reg   <= cnt_uncorr_next;
            log_valid_reg    <= log_valid_next;
            log_tag_reg      <= log_tag_next;
            log_lane_reg     <= log_lane_next;
            log_syndrome_reg <= log_syndrome_next;
            irq_reg          <= log_valid_next;
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_data      = out_data_reg;
    assign out_tag       = out_tag_reg;
    assign out_corrected = out_corrected_reg;
    assign out_invalid   = out_invalid_reg;
    assign cnt_corr      = cnt_corr_reg;
    assign cnt_uncorr    = cnt_uncorr_reg;
    assign log_valid     = log_valid_reg;
    assign log_tag       = log_tag_reg;
    assign log_lane      = log_lane_reg;
    assign log_syndrome  = log_syndrome_reg;
    assign irq           = irq_reg;

endmodule

// File: tb/tb_vx_secded_dec_pipe.sv
// Scoreboard bench for vx_secded_dec_pipe (8-bit data, 2 lanes, 4-bit counters):
// directed scenarios followed by randomized traffic with random back-pressure and clears.
module tb_vx_secded_dec_pipe;

    localparam int DB = 8;
    localparam int LN = 2;
    localparam int TW = 8;
    localparam int CB = 4;
    localparam int HB = 4;
    localparam int EB = 13;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, in_valid, in_ready, out_valid, out_ready, clr, log_valid, irq;
    logic [LN*EB-1:0] in_data;
    logic [TW-1:0]    in_tag, out_tag, log_tag;
    logic [LN*DB-1:0] out_data;
    logic [LN-1:0]    out_corrected, out_invalid;
    logic [CB-1:0]    cnt_corr, cnt_uncorr;
    logic [0:0]       log_lane;
    logic [HB-1:0]    log_syndrome;

    vx_secded_dec_pipe #(
        .DATA_BITS (DB),
        .LANES     (LN),
        .TAG_BITS  (TW),
        .CNT_BITS  (CB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_tag       (out_tag),
        .out_corrected (out_corrected),
        .out_invalid   (out_invalid),
        .cnt_corr      (cnt_corr),
        .cnt_uncorr    (cnt_uncorr),
        .clr           (clr),
        .log_valid     (log_valid),
        .log_tag       (log_tag),
        .log_lane      (log_lane),
        .log_syndrome  (log_syndrome),
        .irq           (irq)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  corr;
        logic [1:0]  inv;
        logic [7:0]  syn;
        logic [7:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t pend;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state: value each DUT register should hold after the most recent edge.
    int         m_cc = 0;
    int         m_cu = 0;
    bit         m_lv = 1'b0;
    logic [7:0] m_ltag = '0;
    logic       m_llane = 1'b0;
    logic [3:0] m_lsyn = '0;

    bit          after_reset = 1'b0;
    bit          st_prev = 1'b0;
    logic [15:0] st_data;
    logic [7:0]  st_tag;
    logic [1:0]  st_corr, st_inv;
    exp_t        mon_e;
    bit          have_e;
    bit          rand_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [12:0] cw;
        logic        b;
        int          k;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[k];
                k++;
            end
        end
        for (int p = 0; p < 4; p++) begin
            b = 1'b0;
            for (int pos = 1; pos <= 12; pos++)
                if ((((pos >> p) & 1) == 1) && ((pos & (pos - 1)) != 0)) b = b ^ cw[pos-1];
            cw[(1 << p) - 1] = b;
        end
        cw[12] = ^cw[11:0];
        return cw;
    endfunction

    function automatic logic [7:0] extract(input logic [12:0] cw);
        logic [7:0] d;
        int         k;
        d = '0;
        k = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = cw[pos-1];
                k++;
            end
        end
        return d;
    endfunction

    // Outcome derived from the injected error pattern: the syndrome of an error set is
    // the XOR of its positions; one flip is always recoverable, two never are, and the
    // three-flip patterns used here always point past the end of the word.
    task automatic lane_model(input logic [7:0] d, input logic [12:0] f,
                              output logic [7:0] od, output logic c, output logic v,
                              output logic [3:0] s);
        int n;
        n = $countones(f);
        s = '0;
        for (int idx = 0; idx < 12; idx++)
            if (f[idx]) s = s ^ 4'(idx + 1);
        c = 1'b0;
        v = 1'b0;
        od = d;
        if (n == 1) c = 1'b1;
        else if (n >= 2) begin
            v  = 1'b1;
            od = extract(encode(d) ^ f);
        end
    endtask

    function automatic logic [12:0] rand_mask();
        logic [12:0] m;
        int r, a, b;
        m = '0;
        r = $urandom_range(0, 99);
        if (r < 40) return m;
        a = $urandom_range(0, 12);
        if (r < 75) begin
            m[a] = 1'b1;
            return m;
        end
        if (r < 95) begin
            b = (a + 1 + $urandom_range(0, 11)) % 13;
            m[a] = 1'b1;
            m[b] = 1'b1;
            return m;
        end
        a = 1;
        b = 12;
        for (int t = 0; t < 50; t++) begin
            int x, y;
            x = $urandom_range(1, 12);
            y = $urandom_range(1, 12);
            if ((x != y) && ((x ^ y) >= 13)) begin
                a = x;
                b = y;
                break;
            end
        end
        m[12]  = 1'b1;
        m[a-1] = 1'b1;
        m[b-1] = 1'b1;
        return m;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    // Called and returns at posedge+1; holds in_valid until the beat is accepted.
    task automatic send(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [12:0] f0, input logic [12:0] f1, input logic [7:0] tag);
        exp_t       e;
        logic [7:0] od;
        logic       c, v;
        logic [3:0] s;
        int         w;
        lane_model(d0, f0, od, c, v, s);
        e.data[7:0] = od; e.corr[0] = c; e.inv[0] = v; e.syn[3:0] = s;
        lane_model(d1, f1, od, c, v, s);
        e.data[15:8] = od; e.corr[1] = c; e.inv[1] = v; e.syn[7:4] = s;
        e.tag    = tag;
        pend     = e;
        in_data  = {encode(d1) ^ f1, encode(d0) ^ f0};
        in_tag   = tag;
        in_valid = 1'b1;
        for (w = 0; w < 500; w++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
        end
        if (w == 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck low, expected 1 (t=%0t)", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare DUT state against the reference, then advance the reference
    // to what the coming rising edge should produce.
    always @(negedge clk) begin
        check("cnt_corr", 64'(cnt_corr), 64'(m_cc));
        check("cnt_uncorr", 64'(cnt_uncorr), 64'(m_cu));
        check("log_valid", 64'(log_valid), 64'(m_lv));
        check("irq", 64'(irq), 64'(m_lv));
        if (m_lv) begin
            check("log_tag", 64'(log_tag), 64'(m_ltag));
            check("log_lane", 64'(log_lane), 64'(m_llane));
            check("log_syndrome", 64'(log_syndrome), 64'(m_lsyn));
        end
        if (!reset) check("in_ready_in_reset", 64'(in_ready), 64'(0));
        else check("in_ready", 64'(in_ready), 64'((sb_q.size() < 2) || out_ready));
        if (after_reset) check("out_valid_after_reset", 64'(out_valid), 64'(0));
        if (st_prev) begin
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_data", 64'(out_data), 64'(st_data));
            check("stall_tag", 64'(out_tag), 64'(st_tag));
            check("stall_flags", 64'({out_corrected, out_invalid}), 64'({st_corr, st_inv}));
        end

        after_reset = !reset;
        st_prev     = reset && out_valid && !out_ready;
        st_data     = out_data;
        st_tag      = out_tag;
        st_corr     = out_corrected;
        st_inv      = out_invalid;

        if (!reset) begin
            sb_q.delete();
            m_cc = 0; m_cu = 0; m_lv = 1'b0;
            m_ltag = '0; m_llane = 1'b0; m_lsyn = '0;
        end else begin
            have_e = 1'b0;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: tag %0h with empty scoreboard, expected none", out_tag);
                end else begin
                    mon_e  = sb_q.pop_front();
                    have_e = 1'b1;
                    $display("out: tag=%02h data=%04h corr=%b inv=%b (exp data=%04h corr=%b inv=%b)",
                             out_tag, out_data, out_corrected, out_invalid,
                             mon_e.data, mon_e.corr, mon_e.inv);
                    check("out_data", 64'(out_data), 64'(mon_e.data));
                    check("out_tag", 64'(out_tag), 64'(mon_e.tag));
                    check("out_corrected", 64'(out_corrected), 64'(mon_e.corr));
                    check("out_invalid", 64'(out_invalid), 64'(mon_e.inv));
                end
            end
            if (clr) begin
                m_cc = 0;
                m_cu = 0;
            end else if (have_e) begin
                if ((|mon_e.corr) && m_cc < CNT_MAX) m_cc++;
                if ((|mon_e.inv) && m_cu < CNT_MAX) m_cu++;
            end
            if (have_e && (|mon_e.inv) && (!m_lv || clr)) begin
                m_lv    = 1'b1;
                m_ltag  = mon_e.tag;
                m_llane = !mon_e.inv[0];
                m_lsyn  = mon_e.inv[0] ? mon_e.syn[3:0] : mon_e.syn[7:4];
            end else if (clr) begin
                m_lv = 1'b0;
            end
            if (in_valid && in_ready) sb_q.push_back(pend);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0;
        out_ready = 1'b1; clr = 1'b0; pend = '0; rand_done = 1'b0;
        idle(3);
        reset = 1'b1;

        // Clean beat, two-cycle latency.
        send(8'hA5, 8'hA5, 13'h0, 13'h0, 8'h11);
        @(negedge clk);
        check("latency_s1_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("latency_s2_out_valid", 64'(out_valid), 64'(1));
        check("clean_data", 64'(out_data), 64'(16'hA5A5));
        @(posedge clk); #1;
        idle(3);

        // Single-bit error on lane 1.
        send(8'hA5, 8'hA5, 13'h0, 13'h010, 8'h22);
        idle(4);
        check("single_err_cnt_corr", 64'(cnt_corr), 64'(1));

        // Double error on lane 0, then a second error that must not overwrite the log.
        send(8'hA5, 8'hA5, 13'h024, 13'h0, 8'h3C);
        idle(4);
        check("dbl_log_tag", 64'(log_tag), 64'(8'h3C));
        check("dbl_log_lane", 64'(log_lane), 64'(0));
        check("dbl_irq", 64'(irq), 64'(1));
        check("dbl_cnt_uncorr", 64'(cnt_uncorr), 64'(1));
        send(8'h5A, 8'hC3, 13'h0, 13'h081, 8'h77);
        idle(4);
        check("log_held_tag", 64'(log_tag), 64'(8'h3C));
        pulse_clr();
        idle(1);
        check("clr_log_valid", 64'(log_valid), 64'(0));
        check("clr_cnt_corr", 64'(cnt_corr), 64'(0));
        check("clr_cnt_uncorr", 64'(cnt_uncorr), 64'(0));

        // Back-to-back beats under a 1,0,0,1 out_ready pattern.
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(8'($urandom), 8'($urandom), rand_mask(), rand_mask(), 8'(8'h40 + i));
            end
            begin
                out_ready = 1'b1; idle(1);
                out_ready = 1'b0; idle(1);
                out_ready = 1'b0; idle(1);
                out_ready = 1'b1;
            end
        join
        idle(5);

        // Counter saturation, then clr against a coincident corrected transfer.
        pulse_clr();
        for (int i = 0; i < 14; i++)
            send(8'($urandom), 8'($urandom), 13'(1 << $urandom_range(0, 12)), 13'h0, 8'(i));
        idle(4);
        check("sat_cnt_14", 64'(cnt_corr), 64'(14));
        for (int i = 0; i < 3; i++)
            send(8'($urandom), 8'($urandom), 13'h0, 13'(1 << $urandom_range(0, 12)), 8'(8'h80 + i));
        idle(4);
        check("sat_cnt_max", 64'(cnt_corr), 64'(CNT_MAX));
        send(8'h12, 8'h34, 13'h002, 13'h0, 8'h99);
        idle(1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(1);
        check("clr_wins_cnt_corr", 64'(cnt_corr), 64'(0));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(8'h01, 8'h02, 13'h0, 13'h0, 8'hE1);
        send(8'h03, 8'h04, 13'h0, 13'h0, 8'hE2);
        reset = 1'b0;
        out_ready = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(2);
        check("post_reset_out_valid", 64'(out_valid), 64'(0));
        send(8'hA5, 8'h5A, 13'h0, 13'h0, 8'hE3);
        idle(4);

        // Randomized traffic with back-pressure and occasional clears.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(8'($urandom), 8'($urandom), rand_mask(), rand_mask(), 8'($urandom));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    clr = ($urandom_range(0, 49) == 0);
                    idle(1);
                end
                out_ready = 1'b1;
                clr = 1'b0;
            end
        join
        idle(10);
        check("drain_empty", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vx_secded_dec_pipe.md
VX_SECDED_DEC_PIPE -- requirements
Module: VX_secded_dec_pipe

Interface
REQ-001 SHALL have parameter DATA_BITS, default 128: data bits per lane.
REQ-002 SHALL have parameter LANES, default 4: independent codewords decoded per beat.
REQ-003 SHALL have parameter TAG_BITS, default 8: sideband tag carried with each beat.
REQ-004 SHALL have parameter CNT_BITS, default 16: width of the error counters.
REQ-005 SHALL derive HAMMING_BITS as the smallest r with 2^r >= DATA_BITS+r+1, and ENCODED_BITS as DATA_BITS+HAMMING_BITS+1.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-008 SHALL have ports in_valid/in_ready (input/output, 1 each), in_data (input, LANES*ENCODED_BITS) and in_tag (input, TAG_BITS); lane i occupies slice i.
REQ-009 SHALL have ports out_valid/out_ready (output/input, 1 each), out_data (output, LANES*DATA_BITS), out_tag (output, TAG_BITS), out_corrected and out_invalid (output, LANES each).
REQ-010 SHALL have ports cnt_corr and cnt_uncorr (output, CNT_BITS each) and clr (input, 1): pulse that clears the counters and the log.
REQ-011 SHALL have ports log_valid (output, 1), log_tag (TAG_BITS), log_lane (clog2(LANES), minimum 1), log_syndrome (HAMMING_BITS) and irq (output, 1).

Function
REQ-012 Codeword format SHALL be Hamming positions 1..ENCODED_BITS-1 at bit index pos-1; power-of-two positions hold check bits; data fills the remaining positions in ascending order; the MSB holds even overall parity.
REQ-013 Per lane, SHALL compute syndrome s (bit p = XOR of bits whose position has bit p set) and parity q (XOR of all ENCODED_BITS bits).
REQ-014 Classification: s=0,q=0 -> clean; q=1,s=0 -> corrected (parity bit only, data unchanged); q=1, 0<s<ENCODED_BITS -> flip position s, corrected; q=1, s>=ENCODED_BITS -> invalid; q=0, s!=0 -> invalid (double error).
REQ-015 Invalid lanes SHALL output uncorrected extracted data, with out_corrected=0 and out_invalid=1.
REQ-016 Pipeline SHALL be two registered stages: S1 (syndrome, parity, codeword, tag) and S2 (corrected data, flags, tag); the latency from in accept to out_valid is 2 cycles with out_ready held high.
REQ-017 Each stage SHALL advance when it is empty or the next stage advances; in_ready = !S1_valid | S1_advance; the pipeline sustains 1 beat per cycle.
REQ-018 While out_valid=1 and out_ready=0, out_* SHALL hold stable; no beat is dropped or duplicated.
REQ-019 On each out transfer (out_valid & out_ready): cnt_corr increments by 1 if any lane is corrected, and cnt_uncorr increments by 1 if any lane is invalid; both saturate at all-ones.
REQ-020 If clr and an increment coincide, the counter SHALL become 0 (clr wins).
REQ-021 On the first out transfer with any invalid lane while log_valid=0, SHALL capture log_tag, the lowest invalid lane index and that lane's syndrome, and set log_valid=1; later errors do not overwrite the log.
REQ-022 clr SHALL clear log_valid; if clr coincides with a capturing transfer, the new error is captured (log_valid=1).
REQ-023 irq SHALL equal log_valid, registered.

Reset
REQ-024 While reset=0 at a clock edge: S1/S2 valid, out_valid, counters, log_* and irq SHALL become 0; in_ready SHALL be 0 during reset and 1 in the first cycle after.
REQ-025 Reset mid-operation SHALL discard all in-flight beats; no out transfer occurs for them.

Structure
REQ-026 Package VX_ecc_pkg SHALL hold the HAMMING_BITS/ENCODED_BITS width functions and the lane-status encoding (clean/corrected/invalid).
REQ-027 Sub-module VX_secded_lane (combinational syndrome, classify, correct, extract) SHALL be instantiated LANES times.

Verification (DATA_BITS=8 -> ENCODED_BITS=13, LANES=2)
REQ-028 Encode 0xA5 on both lanes, no errors -> out_data=0xA5A5 two cycles later, flags 00, counters 0.
REQ-029 Lane1 bit index 4 flipped -> lane1 data 0xA5, out_corrected=2'b10, cnt_corr=1.
REQ-030 Lane0 bits 2 and 5 flipped, tag 0x3C -> out_invalid=2'b01, cnt_uncorr=1, log_tag=0x3C, log_lane=0, irq=1; second error leaves log unchanged; clr -> log_valid=0, counters 0.
REQ-031 Back-to-back beats with out_ready toggling 1,0,0,1 -> in-order output, stable during stall, no loss; in_ready=0 when both stages are full.
REQ-032 Preload cnt_corr to all-ones minus 1, send 3 corrected beats -> counter stays all-ones; clr with a coincident corrected beat -> counter 0.
REQ-033 Assert reset with two beats in flight -> out_valid=0, no transfers; traffic resumes correctly after reset.
